// File: rtl/sb_inst_queue.sv
// sb_inst_queue: circular instruction FIFO between Fetch and Issue.
// Each accepted instruction is stamped with a monotonically increasing
// order number; flush empties the queue and rewinds the order counter.
// Optional same-cycle empty-queue bypass: define SB_IQ_BYPASS_EN.
module sb_inst_queue #(
   parameter int DEPTH   = 8,
   parameter int XLEN    = 32,
   parameter int ORDER_W = 64,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [ORDER_W-1:0] flush_order,
   input  logic               enq_valid,
   output logic               enq_ready,
   input  logic [XLEN-1:0]    enq_inst,
   input  logic [XLEN-1:0]    enq_pc,
   output logic               deq_valid,
   input  logic               deq_ready,
   output logic [XLEN-1:0]    deq_inst,
   output logic [XLEN-1:0]    deq_pc,
   output logic [ORDER_W-1:0] deq_order,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointer MSB is the wrap bit; the low bits index the storage.
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [ORDER_W-1:0] next_order;

   logic [XLEN-1:0]    inst_mem  [DEPTH];
   logic [XLEN-1:0]    pc_mem    [DEPTH];
   logic [ORDER_W-1:0] order_mem [DEPTH];

   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic               enq_fire;
   logic               deq_fire;
   logic               bypass;
   logic               bypass_take;
   logic               wr_en;
   logic               rd_en;

   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign rd_idx = rd_ptr[IDX_W-1:0];

   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
   assign empty = (wr_ptr == rd_ptr);

   // Ready depends only on registered state and flush, never on deq_ready,
   // so a dequeue from a full queue cannot open a same-cycle enqueue slot.
   assign enq_ready = !full && !flush;

`ifdef SB_IQ_BYPASS_EN
   // An empty queue forwards the incoming instruction straight to Issue.
   assign bypass = empty && enq_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign deq_valid = !empty || bypass;
   assign deq_inst  = bypass ? enq_inst   : inst_mem[rd_idx];
   assign deq_pc    = bypass ? enq_pc     : pc_mem[rd_idx];
   assign deq_order = bypass ? next_order : order_mem[rd_idx];

   assign enq_fire    = enq_valid && enq_ready;
   assign deq_fire    = deq_valid && deq_ready;
   // A bypassed instruction consumed in the same cycle never touches storage.
   assign bypass_take = bypass && deq_ready;
   assign wr_en       = enq_fire && !bypass_take;
   assign rd_en       = deq_fire && !bypass_take;

   // Pointer, occupancy and order-number control; reset beats flush beats handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         next_order <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         next_order <= flush_order;
      end else begin
         if (enq_fire) begin
            next_order <= next_order + ORDER_W'(1);
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         inst_mem[wr_idx]  <= enq_inst;
         pc_mem[wr_idx]    <= enq_pc;
         order_mem[wr_idx] <= next_order;
      end
   end

endmodule
